// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Types and constants shared by the I2C memory slave and its storage.
//   slv_state_e     : one-hot slave state encoding
//   I2C_ADDR_WIDTH  : default received address width (7)
//   I2C_DATA_WIDTH  : default data byte width (8)
//   max_int()       : elaboration-time helper for sizing counters
// ----------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;

  typedef enum logic [7:0] {
    IDLE  = 8'b0000_0001,
    ADDR  = 8'b0000_0010,
    RW    = 8'b0000_0100,
    ACK_A = 8'b0000_1000,
    WDATA = 8'b0001_0000,
    ACK_D = 8'b0010_0000,
    RDATA = 8'b0100_0000,
    STOP  = 8'b1000_0000
  } slv_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_slv_mem.sv
// ----------------------------------------------------------------------------
// i2c_slv_mem
// Byte storage behind the I2C slave: MEM_DEPTH x DATA_WIDTH, synchronous
// write, combinational read. Contents are deliberately not reset.
// Optional feature macro: I2C_SLV_READ_EN adds the read port.
// Ports:
//   clk      in   write clock
//   we_i     in   write enable for this cycle
//   addr_i   in   location index
//   wdata_i  in   write data
//   rdata_o  out  read data (only with I2C_SLV_READ_EN)
// ----------------------------------------------------------------------------
module i2c_slv_mem
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int MEM_DEPTH  = 128,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i
`ifdef I2C_SLV_READ_EN
  ,
  output logic [DATA_WIDTH-1:0] rdata_o
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [0:MEM_DEPTH-1];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

`ifdef I2C_SLV_READ_EN
  assign rdata_o = mem_q[addr_i];
`endif

endmodule

// File: rtl/i2c_mem_slave.sv
// ----------------------------------------------------------------------------
// i2c_mem_slave
// Simplified I2C-style memory slave. SCL is clk during a transfer. After a
// start (SDA high then low while idle) it receives an LSB-first address and
// an R/W bit (1 = write), acknowledges in-range addresses, then either
// receives a data byte and commits it, or (with I2C_SLV_READ_EN) returns
// the stored byte LSB-first. Without I2C_SLV_READ_EN every read is NACKed.
// Ports:
//   clk      in   clock, all sampling on the rising edge
//   reset_n  in   synchronous active-low reset
//   S_EN     in   slave enable, low aborts to IDLE
//   SDA_IN   in   serial data from the master
//   ack_n    out  active-low acknowledge
//   SDA_OUT  out  read data bit (idles high)
//   sda_oe   out  high while SDA_OUT carries read data
//   wr_done  out  one-cycle pulse after a byte is committed
//   busy     out  high whenever the slave is not idle
// ----------------------------------------------------------------------------
module i2c_mem_slave
  import i2c_pkg::*;
#(
  parameter int ADDR_WIDTH = I2C_ADDR_WIDTH,
  parameter int DATA_WIDTH = I2C_DATA_WIDTH,
  parameter int MEM_DEPTH  = 128
) (
  input  logic clk,
  input  logic reset_n,
  input  logic S_EN,
  input  logic SDA_IN,
  output logic ack_n,
  output logic SDA_OUT,
  output logic sda_oe,
  output logic wr_done,
  output logic busy
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(max_int(ADDR_WIDTH, DATA_WIDTH));
  localparam logic [ADDR_WIDTH:0]  DEPTH_C    = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [CNT_W-1:0]     ADDR_LAST  = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]     DATA_LAST  = CNT_W'(DATA_WIDTH - 1);

  slv_state_e              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  // Holds the first DATA_WIDTH-1 bits; the last bit is taken straight from
  // SDA_IN so the commit can happen on the edge that samples it.
  logic [DATA_WIDTH-2:0]   data_q;
  logic                    rw_q;
  logic                    sda_q;
  logic                    ack_n_q;
  logic                    sda_out_q;
  logic                    sda_oe_q;
  logic                    wr_done_q;
  logic                    busy_q;

  logic                    addr_ok_s;
  logic                    we_s;
  logic [DATA_WIDTH-1:0]   wdata_s;
  logic [IDX_W-1:0]        idx_s;
`ifdef I2C_SLV_READ_EN
  logic [DATA_WIDTH-1:0]   rdata_s;
`endif

  assign addr_ok_s = ({1'b0, addr_q} < DEPTH_C);
  assign idx_s     = addr_q[IDX_W-1:0];
  assign wdata_s   = {SDA_IN, data_q};
  // Reset and enable gate the write so an aborted transfer never commits.
  assign we_s      = reset_n && S_EN && (state_q == WDATA) && (cnt_q == DATA_LAST);

  i2c_slv_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (we_s),
    .addr_i  (idx_s),
    .wdata_i (wdata_s)
`ifdef I2C_SLV_READ_EN
    ,
    .rdata_o (rdata_s)
`endif
  );

  // Slave FSM with its registered outputs and shift registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rw_q      <= 1'b0;
      sda_q     <= 1'b1;
      ack_n_q   <= 1'b1;
      sda_out_q <= 1'b1;
      sda_oe_q  <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (!S_EN) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sda_q     <= SDA_IN;
      ack_n_q   <= 1'b1;
      sda_out_q <= 1'b1;
      sda_oe_q  <= 1'b0;
      wr_done_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sda_q     <= SDA_IN;
      wr_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // An unknown SDA_IN makes this condition non-true, so X is never a start.
          if (sda_q && !SDA_IN) begin
            state_q <= ADDR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            busy_q  <= 1'b0;
          end
        end
        ADDR: begin
          addr_q <= {SDA_IN, addr_q[ADDR_WIDTH-1:1]};
          if (cnt_q == ADDR_LAST) begin
            state_q <= RW;
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        RW: begin
          rw_q  <= SDA_IN;
          cnt_q <= '0;
`ifdef I2C_SLV_READ_EN
          if (addr_ok_s) begin
`else
          if (addr_ok_s && SDA_IN) begin
`endif
            state_q <= ACK_A;
            ack_n_q <= 1'b0;
          end else begin
            state_q <= STOP;
          end
        end
        ACK_A: begin
          ack_n_q <= 1'b1;
          cnt_q   <= '0;
          if (rw_q) begin
            state_q <= WDATA;
          end else begin
`ifdef I2C_SLV_READ_EN
            state_q   <= RDATA;
            sda_oe_q  <= 1'b1;
            sda_out_q <= rdata_s[0];
            data_q    <= rdata_s[DATA_WIDTH-1:1];
`else
            state_q   <= STOP;
`endif
          end
        end
        WDATA: begin
          data_q <= {SDA_IN, data_q[DATA_WIDTH-2:1]};
          if (cnt_q == DATA_LAST) begin
            state_q   <= ACK_D;
            cnt_q     <= '0;
            ack_n_q   <= 1'b0;
            wr_done_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
          end
        end
        ACK_D: begin
          state_q <= STOP;
          cnt_q   <= '0;
          ack_n_q <= 1'b1;
        end
`ifdef I2C_SLV_READ_EN
        RDATA: begin
          if (cnt_q == DATA_LAST) begin
            state_q   <= STOP;
            cnt_q     <= '0;
            sda_oe_q  <= 1'b0;
            sda_out_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
            sda_out_q <= data_q[0];
            data_q    <= {1'b0, data_q[DATA_WIDTH-2:1]};
          end
        end
`endif
        STOP: begin
          if (SDA_IN) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          ack_n_q   <= 1'b1;
          sda_out_q <= 1'b1;
          sda_oe_q  <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ack_n   = ack_n_q;
  assign SDA_OUT = sda_out_q;
  assign sda_oe  = sda_oe_q;
  assign wr_done = wr_done_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_mem_slave.sv
// ----------------------------------------------------------------------------
// tb_i2c_mem_slave
// Self-checking bench for i2c_mem_slave (MEM_DEPTH=64). Cycle tk is the
// clock period that ends at rising edge tk; outputs are sampled on the
// falling edge inside each cycle, and inputs are driven right after.
// ----------------------------------------------------------------------------
module tb_i2c_mem_slave;

  localparam int DEPTH = 64;
`ifdef I2C_SLV_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic S_EN    = 1'b1;
  logic SDA_IN  = 1'b1;
  logic ack_n, SDA_OUT, sda_oe, wr_done, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory: value plus "has been written" flag per address.
  logic [7:0] ref_mem [0:127];
  bit         ref_vld [0:127];

  i2c_mem_slave #(
    .ADDR_WIDTH (7),
    .DATA_WIDTH (8),
    .MEM_DEPTH  (DEPTH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .S_EN    (S_EN),
    .SDA_IN  (SDA_IN),
    .ack_n   (ack_n),
    .SDA_OUT (SDA_OUT),
    .sda_oe  (sda_oe),
    .wr_done (wr_done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input int k, input bit ack_e, input bit out_e,
                          input bit oe_e, input bit wrd_e, input bit busy_e, input bit out_known);
    chk($sformatf("%s.t%0d.ack_n", tag, k), ack_n, ack_e);
    chk($sformatf("%s.t%0d.sda_oe", tag, k), sda_oe, oe_e);
    chk($sformatf("%s.t%0d.wr_done", tag, k), wr_done, wrd_e);
    chk($sformatf("%s.t%0d.busy", tag, k), busy, busy_e);
    if (out_known) chk($sformatf("%s.t%0d.sda_out", tag, k), SDA_OUT, out_e);
  endtask

  // One transfer from start to return-to-idle. abort_at < 0 means no abort;
  // otherwise S_EN (or reset_n when abort_rst) is low at edge t<abort_at>.
  task automatic xfer(input string tag, input logic [6:0] a, input bit rw, input logic [7:0] d,
                      input int hold, input int abort_at, input bit abort_rst);
    bit ok, committed, aborted, v;
    int s, last;
    logic [7:0] rd;
    bit rd_known;
    ok        = (int'(a) < DEPTH) && (rw || READ_EN);
    s         = !ok ? 9 : (rw ? 19 : 18);   // first cycle spent in STOP
    last      = s + hold;                   // last busy cycle
    rd        = ref_mem[a];
    rd_known  = ref_vld[a];
    aborted   = 1'b0;
    committed = ok && rw && (abort_at < 0 || abort_at > 17);
    for (int k = 0; k <= last + 1; k++) begin
      @(negedge clk);
      if (k > 0 && abort_at >= 0 && k == abort_at + 1) begin
        chk_outs({tag, ".abort"}, k, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        reset_n = 1'b1;
        S_EN    = 1'b1;
        SDA_IN  = 1'b1;
        @(negedge clk);
        chk($sformatf("%s.post_abort.busy", tag), busy, 1'b0);
        aborted = 1'b1;
        break;
      end
      if (k > 0) begin
        bit oe_e;
        oe_e = ok && !rw && k >= 10 && k <= 17;
        chk_outs(tag, k,
                 !(ok && (k == 9 || (rw && k == 18))),
                 oe_e ? rd[k-10] : 1'b1,
                 oe_e,
                 ok && rw && k == 18,
                 k <= last,
                 !(oe_e && !rd_known));
      end
      if (k <= last) begin
        if (k == 0)                           v = 1'b0;
        else if (k <= 7)                      v = a[k-1];
        else if (k == 8)                      v = rw;
        else if (k >= s)                      v = (k == last);
        else if (rw && k >= 10 && k <= 17)    v = d[k-10];
        else                                  v = 1'($urandom_range(0, 1));
        SDA_IN = v;
        if (k == abort_at) begin
          if (abort_rst) reset_n = 1'b0;
          else           S_EN    = 1'b0;
        end
      end
    end
    if (committed) begin
      ref_mem[a] = d;
      ref_vld[a] = 1'b1;
    end
    if (int'(a) < DEPTH && ref_vld[a])
      chk($sformatf("%s.mem[%0h]%s", tag, a, aborted ? ".abort" : ""),
          dut.u_mem.mem_q[int'(a)], ref_mem[a]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      ref_mem[i] = 8'h00;
      ref_vld[i] = 1'b0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    chk_outs("reset", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    chk_outs("after_reset", 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Directed cases.
    xfer("wr15",     7'h15, 1'b1, 8'hA5, 0, -1, 1'b0);
    xfer("wr50_oor", 7'h50, 1'b1, 8'h3C, 2, -1, 1'b0);
    xfer("rd15",     7'h15, 1'b0, 8'h00, 0, -1, 1'b0);
    xfer("rd02",     7'h02, 1'b0, 8'h00, 1, -1, 1'b0);
    xfer("wr30",     7'h30, 1'b1, 8'h11, 0, -1, 1'b0);
    xfer("wr30_rst", 7'h30, 1'b1, 8'h5A, 0, 12, 1'b1);
    xfer("wr01_en",  7'h01, 1'b1, 8'h77, 0,  5, 1'b0);
    xfer("wr01",     7'h01, 1'b1, 8'h3C, 0, -1, 1'b0);
    xfer("wr15_t17", 7'h15, 1'b1, 8'hFF, 0, 17, 1'b0);
    xfer("wr22_t18", 7'h22, 1'b1, 8'h99, 0, 18, 1'b0);
    xfer("wr3f_max", 7'h3F, 1'b1, 8'h81, 0, -1, 1'b0);
    xfer("wr40_oor", 7'h40, 1'b1, 8'h42, 0, -1, 1'b0);
    xfer("rd3f",     7'h3F, 1'b0, 8'h00, 0, -1, 1'b0);

    // Randomized transfers.
    for (int n = 0; n < 40; n++) begin
      logic [6:0] a;
      int ab;
      a  = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, DEPTH - 1)) : 7'($urandom_range(0, 127));
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 18)) : -1;
      xfer($sformatf("rnd%0d", n), a, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           int'($urandom_range(0, 2)), ab, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
